// File: rtl/wptr_full_ctrl_pkg.sv
// Shared FIFO helpers: pointer width and Gray/binary conversion.
// Conversions work on a 32-bit container; callers size-cast in and out.
package wptr_full_ctrl_pkg;

    localparam int CONV_W        = 32;
    localparam int DEF_ADDR_SIZE = 8;

    // Pointers carry one wrap bit above the memory address.
    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_ADDR_SIZE);

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin_f(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Width-parameterised Gray-to-binary converter, purely combinational.
module gray2bin
    import wptr_full_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_PTR_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Zero-extending a Gray code keeps the low bits' binary value intact.
    assign bin = WIDTH'(gray2bin_f(CONV_W'(gray)));

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full, occupancy and sticky overflow
// control for an async FIFO; wq2_rptr arrives already synchronised.
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE    = 8,
    parameter int AFULL_THRESH = 2**ADDR_SIZE - 4
) (
    input  logic                   w_clk_i,
    input  logic                   w_rst_i,
    input  logic                   w_inc_i,
    input  logic [ADDR_SIZE:0]     wq2_rptr_i,
    input  logic                   w_ovf_clr_i,
    output logic [ADDR_SIZE:0]     w_ptr_o,
    output logic [ADDR_SIZE-1:0]   w_addr_o,
    output logic                   w_en_o,
    output logic                   w_full_o,
    output logic                   w_afull_o,
    output logic [ADDR_SIZE:0]     w_level_o,
    output logic                   w_ovf_o
);

    localparam int PTR_W = ptr_width(ADDR_SIZE);
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wgray;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rgray_full;
    logic [PTR_W-1:0] level_next;
    logic             accept;

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray (wq2_rptr_i),
        .bin  (rbin)
    );

    // Reset gating keeps the memory quiet while the block is held in reset.
    assign accept     = w_inc_i & ~w_full_o & w_rst_i;
    assign w_en_o     = accept;
    assign wbin_next  = wbin + PTR_W'(accept);
    assign wgray_next = PTR_W'(bin2gray(CONV_W'(wbin_next)));
    assign level_next = wbin_next - rbin;

    // Full when the write pointer has lapped the read pointer exactly once.
    assign rgray_full = {~wq2_rptr_i[PTR_W-1:PTR_W-2], wq2_rptr_i[PTR_W-3:0]};

    always_ff @(posedge w_clk_i or negedge w_rst_i) begin
        if (!w_rst_i) begin
            wbin      <= '0;
            wgray     <= '0;
            w_full_o  <= 1'b0;
            w_afull_o <= 1'b0;
            w_level_o <= '0;
            w_ovf_o   <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wgray     <= wgray_next;
            w_full_o  <= (wgray_next == rgray_full);
            w_afull_o <= (level_next >= AFULL_LVL);
            w_level_o <= level_next;
            if (w_inc_i && w_full_o) begin
                w_ovf_o <= 1'b1;
            end else if (w_ovf_clr_i) begin
                w_ovf_o <= 1'b0;
            end
        end
    end

    assign w_ptr_o  = wgray;
    assign w_addr_o = wbin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ADDR_SIZE=3, AFULL_THRESH=6.
module tb_wptr_full_ctrl;

    localparam int AS = 3;

    logic          w_clk_i = 1'b0;
    logic          w_rst_i;
    logic          w_inc_i;
    logic [AS:0]   wq2_rptr_i;
    logic          w_ovf_clr_i;
    logic [AS:0]   w_ptr_o;
    logic [AS-1:0] w_addr_o;
    logic          w_en_o;
    logic          w_full_o;
    logic          w_afull_o;
    logic [AS:0]   w_level_o;
    logic          w_ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    wptr_full_ctrl #(
        .ADDR_SIZE    (AS),
        .AFULL_THRESH (6)
    ) dut (
        .w_clk_i     (w_clk_i),
        .w_rst_i     (w_rst_i),
        .w_inc_i     (w_inc_i),
        .wq2_rptr_i  (wq2_rptr_i),
        .w_ovf_clr_i (w_ovf_clr_i),
        .w_ptr_o     (w_ptr_o),
        .w_addr_o    (w_addr_o),
        .w_en_o      (w_en_o),
        .w_full_o    (w_full_o),
        .w_afull_o   (w_afull_o),
        .w_level_o   (w_level_o),
        .w_ovf_o     (w_ovf_o)
    );

    always #5 w_clk_i = ~w_clk_i;

    // 4-bit binary to Gray lookup, written out by hand.
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ptr"},   32'(w_ptr_o),   32'd0);
        check_val({tag, "_addr"},  32'(w_addr_o),  32'd0);
        check_val({tag, "_level"}, 32'(w_level_o), 32'd0);
        check_val({tag, "_full"},  32'(w_full_o),  32'd0);
        check_val({tag, "_afull"}, 32'(w_afull_o), 32'd0);
        check_val({tag, "_ovf"},   32'(w_ovf_o),   32'd0);
    endtask

    initial begin
        int         wb;
        logic [3:0] prev_ptr;

        w_rst_i     = 1'b0;
        w_inc_i     = 1'b0;
        wq2_rptr_i  = '0;
        w_ovf_clr_i = 1'b0;
        tick();
        tick();
        check_all_zero("rst");
        check_val("rst_en", 32'(w_en_o), 32'd0);
        w_rst_i = 1'b1;

        // Three writes, then reset mid-operation with no clock edge.
        w_inc_i = 1'b1;
        tick();
        tick();
        tick();
        check_val("pre_rst_ptr",   32'(w_ptr_o),   32'(4'b0010));
        check_val("pre_rst_addr",  32'(w_addr_o),  32'd3);
        check_val("pre_rst_level", 32'(w_level_o), 32'd3);
        w_rst_i = 1'b0;
        #2;
        check_all_zero("async_rst");
        check_val("async_rst_en", 32'(w_en_o), 32'd0);
        tick();

        // Release and fill eight entries with the read pointer parked at 0.
        w_rst_i = 1'b1;
        #1;
        check_val("post_rst_en", 32'(w_en_o), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val($sformatf("fill%0d_level", i), 32'(w_level_o), 32'(i));
            check_val($sformatf("fill%0d_addr", i),  32'(w_addr_o),  32'(i % 8));
            check_val($sformatf("fill%0d_afull", i), 32'(w_afull_o), (i >= 6) ? 32'd1 : 32'd0);
            check_val($sformatf("fill%0d_full", i),  32'(w_full_o),  (i == 8) ? 32'd1 : 32'd0);
        end
        check_val("fill_ptr", 32'(w_ptr_o), 32'(4'b1100));

        // Overflow: rejected write, clear collides with set, then clear alone.
        check_val("ovf_en", 32'(w_en_o), 32'd0);
        tick();
        check_val("ovf_ptr",  32'(w_ptr_o),  32'(4'b1100));
        check_val("ovf_addr", 32'(w_addr_o), 32'd0);
        check_val("ovf_set",  32'(w_ovf_o),  32'd1);
        w_ovf_clr_i = 1'b1;
        tick();
        check_val("ovf_set_wins", 32'(w_ovf_o), 32'd1);
        w_inc_i = 1'b0;
        tick();
        check_val("ovf_clr", 32'(w_ovf_o), 32'd0);
        w_ovf_clr_i = 1'b0;

        // Drain release: reader has advanced to binary 2.
        wq2_rptr_i = 4'b0011;
        tick();
        check_val("drain_full",  32'(w_full_o),  32'd0);
        check_val("drain_level", 32'(w_level_o), 32'd6);
        check_val("drain_afull", 32'(w_afull_o), 32'd1);
        check_val("drain_ptr",   32'(w_ptr_o),   32'(4'b1100));

        // Wrap: reader trails the post-write pointer by three.
        wb = 8;
        w_inc_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            prev_ptr   = w_ptr_o;
            wq2_rptr_i = gray_tab[(wb + 1 - 3) % 16];
            #1;
            check_val($sformatf("wrap%0d_en", i), 32'(w_en_o), 32'd1);
            tick();
            wb = wb + 1;
            check_val($sformatf("wrap%0d_addr", i),  32'(w_addr_o),  32'(wb % 8));
            check_val($sformatf("wrap%0d_ptr", i),   32'(w_ptr_o),   32'(gray_tab[wb % 16]));
            check_val($sformatf("wrap%0d_step", i),  32'($countones(prev_ptr ^ w_ptr_o)), 32'd1);
            check_val($sformatf("wrap%0d_full", i),  32'(w_full_o),  32'd0);
            check_val($sformatf("wrap%0d_level", i), 32'(w_level_o), 32'd3);
        end
        w_inc_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, memory address width; depth = 2^ADDR_SIZE.
REQ-002 SHALL have parameter AFULL_THRESH, default 2^ADDR_SIZE-4, almost-full level.
REQ-003 SHALL have port w_clk_i  in  1  write clock.
REQ-004 SHALL have port w_rst_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port w_inc_i  in  1  write request.
REQ-006 SHALL have port wq2_rptr_i  in  ADDR_SIZE+1  Gray read pointer, already synchronised to w_clk_i.
REQ-007 SHALL have port w_ovf_clr_i  in  1  clear sticky overflow.
REQ-008 SHALL have port w_ptr_o  out  ADDR_SIZE+1  registered Gray write pointer, to read-domain synchroniser.
REQ-009 SHALL have port w_addr_o  out  ADDR_SIZE  binary memory write address.
REQ-010 SHALL have port w_en_o  out  1  memory write enable.
REQ-011 SHALL have port w_full_o  out  1  registered full flag.
REQ-012 SHALL have port w_afull_o  out  1  registered almost-full flag.
REQ-013 SHALL have port w_level_o  out  ADDR_SIZE+1  registered write-side occupancy, 0..depth.
REQ-014 SHALL have port w_ovf_o  out  1  sticky overflow flag.

Function
REQ-015 SHALL hold binary pointer wbin (ADDR_SIZE+1 bits) and Gray pointer wgray, both registered.
REQ-016 SHALL accept a write when w_inc_i=1 and w_full_o=0; w_en_o = w_inc_i & ~w_full_o, combinational, same cycle.
REQ-017 SHALL compute wbin_next = wbin + accept, modulo 2^(ADDR_SIZE+1); wgray_next = (wbin_next>>1) ^ wbin_next.
REQ-018 SHALL drive w_addr_o = wbin[ADDR_SIZE-1:0] and w_ptr_o = wgray.
REQ-019 SHALL register w_full_o = (wgray_next == {~wq2_rptr_i[MSB:MSB-1], wq2_rptr_i[MSB-2:0]}).
REQ-020 SHALL convert wq2_rptr_i Gray-to-binary (rbin) and register w_level_o = wbin_next - rbin, modulo 2^(ADDR_SIZE+1).
REQ-021 SHALL register w_afull_o = (level_next >= AFULL_THRESH).
REQ-022 Full, almost-full and level SHALL update on the cycle after a write or a wq2_rptr_i change; deassertion is conservative (late), never early.
REQ-023 w_ptr_o SHALL change by at most one Gray bit per cycle, including the wrap 2^(ADDR_SIZE+1)-1 -> 0.
REQ-024 w_ovf_o SHALL set when w_inc_i=1 and w_full_o=1; cleared by w_ovf_clr_i; set wins on simultaneous set and clear.
REQ-025 A rejected write SHALL leave wbin, wgray, w_addr_o unchanged.

Reset
REQ-026 w_rst_i low SHALL immediately force wbin, wgray, w_ptr_o, w_addr_o, w_level_o, w_full_o, w_afull_o, w_ovf_o to 0, including mid-operation.
REQ-027 While w_rst_i is low, w_en_o SHALL be 0.
REQ-028 After release, first write SHALL be accepted on the first w_clk_i edge.

Structure
REQ-029 Gray/binary conversion functions and pointer-width constant (ADDR_SIZE+1) SHALL live in the shared fifo package.
REQ-030 Gray-to-binary conversion SHALL be a sub-module, gray2bin, parameterised by width.
REQ-031 The read-to-write synchroniser feeding wq2_rptr_i SHALL be instantiated with width ADDR_SIZE+1; no synchroniser inside this block.

Verification (ADDR_SIZE=3, AFULL_THRESH=6)
REQ-032 Reset: drive w_rst_i low after 3 writes -> all outputs 0 with no clock edge; w_en_o=0.
REQ-033 Fill: wq2_rptr_i=0, 8 consecutive writes -> after 6th accepted write w_afull_o=1, w_level_o=6; after 8th w_full_o=1, w_ptr_o=4'b1100, w_level_o=8.
REQ-034 Overflow: 9th write while full -> w_en_o=0, w_ptr_o unchanged, w_ovf_o=1; w_ovf_clr_i pulse together with another rejected write -> w_ovf_o stays 1; clear alone -> 0.
REQ-035 Drain release: while full, set wq2_rptr_i=4'b0011 (binary 2) -> next cycle w_full_o=0, w_level_o=6, w_afull_o=1.
REQ-036 Wrap: 40 writes with read pointer trailing by 3 -> w_addr_o wraps 7->0, w_ptr_o single-bit transitions, w_full_o never 1, w_level_o=3 in steady state.
